// File: rtl/flag_arbiter_if.sv
// Flag-write bus between the three requesters / trap sequencer and flag_arbiter.
// master = requester/CPU side, slave = arbiter side.
interface flag_arbiter_if;
  logic        alu_req;
  logic [12:0] alu_data;
  logic [12:0] alu_mask;
  logic        alu_gnt;
  logic        mov_req;
  logic [12:0] mov_data;
  logic [12:0] mov_mask;
  logic        mov_gnt;
  logic        sys_req;
  logic [12:0] sys_data;
  logic [12:0] sys_mask;
  logic        sys_gnt;
  logic        retire;
  logic        trap_ack;
  logic        trap_req;
  logic [12:0] flags;

  modport master (
    output alu_req, alu_data, alu_mask,
    output mov_req, mov_data, mov_mask,
    output sys_req, sys_data, sys_mask,
    output retire, trap_ack,
    input  alu_gnt, mov_gnt, sys_gnt, trap_req, flags
  );

  modport slave (
    input  alu_req, alu_data, alu_mask,
    input  mov_req, mov_data, mov_mask,
    input  sys_req, sys_data, sys_mask,
    input  retire, trap_ack,
    output alu_gnt, mov_gnt, sys_gnt, trap_req, flags
  );
endinterface

// File: rtl/flag_arbiter.sv
// CPU flag register with three-way write arbitration and single-step trap sequencing.
// Optional macro FLAG_ARB_STARVE_EN builds wait counters that promote starved alu/mov requests.
module flag_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic          clk,
  input  logic          rst,
  flag_arbiter_if.slave bus
);

  localparam logic [12:0] ALU_LEGAL = 13'h007F;
  localparam logic [12:0] MOV_LEGAL = 13'h0C00;
  localparam logic [12:0] SYS_LEGAL = 13'h1FFF;
  localparam int          TF        = 12;

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] TRAP_WAIT = 1'b1;

  if (MAX_WAIT < 1 || MAX_WAIT > (1 << WAIT_W) - 1) begin : g_bad_wait_param
    $error("flag_arbiter: WAIT_W too narrow for MAX_WAIT");
  end

  logic [0:0]  state;
  logic [12:0] flags;
  logic        run;
  logic        alu_gnt, mov_gnt, sys_gnt;
  logic        alu_prom, mov_prom;
  logic [12:0] wr_mask, wr_data, flags_nxt;

  assign run = (state == RUN);

`ifdef FLAG_ARB_STARVE_EN
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] alu_wait, mov_wait;

  assign alu_prom = run && bus.alu_req && (alu_wait == WAIT_MAX);
  assign mov_prom = run && bus.mov_req && (mov_wait == WAIT_MAX);

  // Counters freeze during TRAP_WAIT so a request keeps its seniority across the trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_wait <= '0;
      mov_wait <= '0;
    end else if (run) begin
      if (!bus.alu_req || alu_gnt)  alu_wait <= '0;
      else if (alu_wait != WAIT_MAX) alu_wait <= alu_wait + 1'b1;
      if (!bus.mov_req || mov_gnt)  mov_wait <= '0;
      else if (mov_wait != WAIT_MAX) mov_wait <= mov_wait + 1'b1;
    end
  end
`else
  assign alu_prom = 1'b0;
  assign mov_prom = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    sys_gnt = 1'b0;
    alu_gnt = 1'b0;
    mov_gnt = 1'b0;
    if (!rst) begin
      if (mov_prom)                 mov_gnt = 1'b1;
      else if (alu_prom)            alu_gnt = 1'b1;
      else if (bus.sys_req)         sys_gnt = 1'b1;
      else if (run && bus.alu_req)  alu_gnt = 1'b1;
      else if (run && bus.mov_req)  mov_gnt = 1'b1;
    end
  end

  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    if (sys_gnt) begin
      wr_mask = bus.sys_mask & SYS_LEGAL;
      wr_data = bus.sys_data;
    end else if (alu_gnt) begin
      wr_mask = bus.alu_mask & ALU_LEGAL;
      wr_data = bus.alu_data;
    end else if (mov_gnt) begin
      wr_mask = bus.mov_mask & MOV_LEGAL;
      wr_data = bus.mov_data;
    end
    flags_nxt = (flags & ~wr_mask) | (wr_data & wr_mask);
    // Acknowledge wins over a same-cycle sys write to tf.
    if (!run && bus.trap_ack) flags_nxt[TF] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
      state <= RUN;
    end else begin
      flags <= flags_nxt;
      case (state)
        RUN:       if (bus.retire && flags[TF]) state <= TRAP_WAIT;
        TRAP_WAIT: if (bus.trap_ack)            state <= RUN;
        default:                                state <= RUN;
      endcase
    end
  end

  assign bus.sys_gnt  = sys_gnt;
  assign bus.alu_gnt  = alu_gnt;
  assign bus.mov_gnt  = mov_gnt;
  assign bus.trap_req = (state == TRAP_WAIT);
  assign bus.flags    = flags;

endmodule

// File: tb/tb_flag_arbiter.sv
// Self-checking bench for flag_arbiter: directed scenarios plus randomized traffic against a reference model.
// Follows FLAG_ARB_STARVE_EN the same way as the design build.
module tb_flag_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flag_arbiter_if bus ();

  flag_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [12:0] m_flags;
  bit          m_trap;
  int          m_aw, m_mw;
  int          exp_who;   // 0 none, 1 sys, 2 alu, 3 mov
  int          dut_who;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input int who, input int b);
    case (who)
      1:       return 1'b1;
      2:       return b <= 6;
      3:       return b == 10 || b == 11;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pick();
    if (rst) return 0;
`ifdef FLAG_ARB_STARVE_EN
    if (!m_trap && bus.mov_req && m_mw == MAX_WAIT) return 3;
    if (!m_trap && bus.alu_req && m_aw == MAX_WAIT) return 2;
`endif
    if (bus.sys_req)            return 1;
    if (!m_trap && bus.alu_req) return 2;
    if (!m_trap && bus.mov_req) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_flags = '0;
    m_trap  = 1'b0;
    m_aw    = 0;
    m_mw    = 0;
  endtask

  task automatic idle();
    bus.sys_req  = 1'b0; bus.sys_data = '0; bus.sys_mask = '0;
    bus.alu_req  = 1'b0; bus.alu_data = '0; bus.alu_mask = '0;
    bus.mov_req  = 1'b0; bus.mov_data = '0; bus.mov_mask = '0;
    bus.retire   = 1'b0;
    bus.trap_ack = 1'b0;
  endtask

  // One clock: compare grants and state at negedge, advance the model, return #1 after posedge.
  task automatic step();
    logic [12:0] nf, d, m;
    bit          nt;
    int          naw, nmw;
    @(negedge clk);
    exp_who = pick();
    dut_who = bus.sys_gnt ? 1 : bus.alu_gnt ? 2 : bus.mov_gnt ? 3 : 0;
    check("sys_gnt",  32'(bus.sys_gnt),  32'(exp_who == 1));
    check("alu_gnt",  32'(bus.alu_gnt),  32'(exp_who == 2));
    check("mov_gnt",  32'(bus.mov_gnt),  32'(exp_who == 3));
    check("flags",    32'(bus.flags),    32'(m_flags));
    check("trap_req", 32'(bus.trap_req), 32'(m_trap));

    d = exp_who == 1 ? bus.sys_data : exp_who == 2 ? bus.alu_data : bus.mov_data;
    m = exp_who == 1 ? bus.sys_mask : exp_who == 2 ? bus.alu_mask : bus.mov_mask;
    nf = m_flags;
    for (int b = 0; b < 13; b++)
      if (legal(exp_who, b) && m[b]) nf[b] = d[b];

    naw = m_aw;
    nmw = m_mw;
    if (!m_trap) begin
      nt  = bus.retire && m_flags[12];
      naw = (bus.alu_req && exp_who != 2) ? ((m_aw + 1 > MAX_WAIT) ? MAX_WAIT : m_aw + 1) : 0;
      nmw = (bus.mov_req && exp_who != 3) ? ((m_mw + 1 > MAX_WAIT) ? MAX_WAIT : m_mw + 1) : 0;
    end else if (bus.trap_ack) begin
      nt     = 1'b0;
      nf[12] = 1'b0;
    end else begin
      nt = 1'b1;
    end

    @(posedge clk);
    #1;
    m_flags = nf;
    m_trap  = nt;
    m_aw    = naw;
    m_mw    = nmw;
  endtask

  task automatic sys_write(input logic [12:0] data, input logic [12:0] mask);
    bus.sys_req = 1'b1; bus.sys_data = data; bus.sys_mask = mask;
    step();
    bus.sys_req = 1'b0;
  endtask

  initial begin
    int first_alu;
    int got [3];

    idle();
    model_reset();
    rst = 1'b1;
    #12;
    check("reset flags",    32'(bus.flags),    32'h0);
    check("reset trap_req", 32'(bus.trap_req), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Async reset mid-cycle with a request pending
    sys_write(13'h1FFF, 13'h1FFF);
    check("sys all ones", 32'(bus.flags), 32'h1FFF);
    bus.alu_req = 1'b1; bus.sys_req = 1'b1; bus.mov_req = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async flags",    32'(bus.flags),    32'h0);
    check("async trap_req", 32'(bus.trap_req), 32'h0);
    check("async gnts",     32'({bus.sys_gnt, bus.alu_gnt, bus.mov_gnt}), 32'h0);
    idle();
    @(posedge clk); #1;
    rst = 1'b0;

    // Mask legality
    bus.alu_req = 1'b1; bus.alu_data = 13'h1FFF; bus.alu_mask = 13'h1FFF;
    step();
    bus.alu_req = 1'b0;
    check("alu legal", 32'(bus.flags), 32'h007F);
    bus.mov_req = 1'b1; bus.mov_data = 13'h1FFF; bus.mov_mask = 13'h1FFF;
    step();
    bus.mov_req = 1'b0;
    check("mov legal", 32'(bus.flags), 32'h0C7F);

    // Simultaneous requests, each dropped after its grant
    bus.sys_req = 1'b1; bus.alu_req = 1'b1; bus.mov_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      got[c] = dut_who;
      if (dut_who == 1) bus.sys_req = 1'b0;
      if (dut_who == 2) bus.alu_req = 1'b0;
      if (dut_who == 3) bus.mov_req = 1'b0;
    end
    check("simul c0 sys", 32'(got[0]), 32'd1);
    check("simul c1 alu", 32'(got[1]), 32'd2);
    check("simul c2 mov", 32'(got[2]), 32'd3);
    idle();

    // Starvation under continuous sys traffic
    first_alu = -1;
    bus.alu_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.sys_req = 1'b1; bus.sys_data = 13'($urandom) & 13'h0FFF; bus.sys_mask = 13'h1FFF;
      step();
      if (dut_who == 2) begin
        if (first_alu < 0) first_alu = c;
        bus.alu_req = 1'b0;
      end
    end
`ifdef FLAG_ARB_STARVE_EN
    check("starve first alu_gnt", 32'(first_alu), 32'd4);
`else
    check("starve first alu_gnt", 32'(first_alu), 32'hFFFF_FFFF);
`endif
    idle();

    // Single-step trap
    sys_write(13'h1000, 13'h1FFF);
    check("tf set", 32'(bus.flags), 32'h1000);
    bus.retire = 1'b1;
    step();
    bus.retire = 1'b0;
    check("trap raised", 32'(bus.trap_req), 32'h1);
    bus.alu_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("alu frozen in trap", 32'(dut_who == 2), 32'h0);
    end
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    check("ack clears tf",   32'(bus.flags),    32'h0);
    check("ack drops trap",  32'(bus.trap_req), 32'h0);
    step();
    check("alu after trap",  32'(dut_who), 32'd2);
    idle();

    // Same-cycle sys clear of tf and retire
    sys_write(13'h1000, 13'h1000);
    bus.sys_req = 1'b1; bus.sys_data = 13'h0; bus.sys_mask = 13'h1000;
    bus.retire  = 1'b1;
    step();
    idle();
    check("race tf cleared", 32'(bus.flags[12]), 32'h0);
    check("race trap",       32'(bus.trap_req), 32'h1);
    bus.trap_ack = 1'b1;
    step();
    idle();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      bus.sys_req  = $urandom_range(0, 99) < 40;
      bus.alu_req  = $urandom_range(0, 99) < 65;
      bus.mov_req  = $urandom_range(0, 99) < 65;
      bus.sys_data = 13'($urandom); bus.sys_mask = 13'($urandom);
      bus.alu_data = 13'($urandom); bus.alu_mask = 13'($urandom);
      bus.mov_data = 13'($urandom); bus.mov_mask = 13'($urandom);
      bus.retire   = $urandom_range(0, 99) < 15;
      bus.trap_ack = $urandom_range(0, 99) < 20;
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flag_arbiter.md
# flag_arbiter

Arbitrates writes into the CPU flag register (zf, sf, of, uf, cffw, cfhl, cfhh, df, hwf, srf, mvf, mcf, tf) between three requesters: the ALU, the move/copy unit and the system/status-write path. The block holds the architectural flag vector and applies each granted write under a per-requester legal-bit mask. It also sequences the single-step trap: a retire pulse while tf is set raises a trap request, and flag writes freeze until the trap is acknowledged.

## Interface
Flag vector bit order: [0]zf [1]sf [2]of [3]uf [4]cffw [5]cfhl [6]cfhh [7]df [8]hwf [9]srf [10]mvf [11]mcf [12]tf.

Parameters:
- MAX_WAIT, 4: waiting cycles after which a pending ALU or move request is promoted.
- WAIT_W, 3: width of the wait counters; must hold MAX_WAIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_req  in  1  ALU flag-write request, held until granted or withdrawn.
- alu_data  in  13  ALU flag values.
- alu_mask  in  13  ALU write mask; only bits 6:0 are honoured.
- alu_gnt  out  1  ALU grant.
- mov_req, mov_data[12:0], mov_mask[12:0], mov_gnt: move unit; only bits 11:10 are honoured.
- sys_req, sys_data[12:0], sys_mask[12:0], sys_gnt: system write; all 13 bits are honoured.
- retire  in  1  one-cycle instruction-retire pulse.
- trap_ack  in  1  trap handler acknowledge.
- trap_req  out  1  single-step trap request.
- flags  out  13  registered flag vector.

## Operation
- Grants are one-hot, and at most one is asserted per cycle.
- Per-requester merge on the edge after a grant: flags <= (flags & ~m) | (data & m), where m = mask & legal_bits.
- Base priority: sys > alu > mov.
- Withdrawing a request (deasserting req without a grant) is legal and has no side effect.
- Wait counters (alu_wait, mov_wait):
  - Increment each cycle the requester's req=1 and its gnt=0.
  - Clear on grant or when req=0.
  - Saturate at MAX_WAIT.
- A requester whose counter equals MAX_WAIT is promoted. Promoted order: mov > alu > sys > unpromoted alu > unpromoted mov.
- State machine:
  - RUN:
    - Normal arbitration.
    - If retire=1 and the registered flags[12]=1, go to TRAP_WAIT on the next edge.
  - TRAP_WAIT:
    - trap_req=1.
    - alu_gnt and mov_gnt are forced to 0; their counters hold (neither increment nor clear).
    - sys requests are still granted.
    - On trap_ack=1: clear tf at that edge and go to RUN. The tf clear overrides any sys write to bit 12 in the same cycle.
- trap_ack in RUN is ignored. retire in TRAP_WAIT is ignored.

## Timing
- Reset values (asynchronous): flags=0, state=RUN, trap_req=0, wait counters 0. All grants are 0 while rst=1.
- Grant is combinational from req, counters and state in the same cycle. The flags update at the following rising edge, so write latency is 1 cycle.
- A requester sees gnt for exactly one cycle per write. It must drop or change req in the cycle after the grant, otherwise it is granted again.
- Trap detection uses flags before that cycle's write. A sys write clearing tf in the same cycle as retire still raises the trap.
- trap_req is registered: it asserts on the first edge after the retire and deasserts on the edge where trap_ack is sampled.
- Reset asserted mid-trap or mid-write aborts the operation. The pending write is lost.

## Configuration
- FLAG_ARB_STARVE_EN:
  - Defined: wait counters and promotion exist as described.
  - Undefined: counters are not built and arbitration is fixed priority sys > alu > mov. A continuously asserted sys_req starves alu and mov indefinitely.

## Test plan
- Reset: drive flags to 0x1FFF via sys, then pulse rst mid-cycle -> flags=0x0000, trap_req=0 and all gnt=0 immediately (asynchronous), with no wait for a clock edge.
- Mask legality: alu_req with data=0x1FFF and mask=0x1FFF from reset -> flags=0x007F. Then mov_req with data=0x1FFF and mask=0x1FFF -> flags=0x0C7F.
- Simultaneous requests (MAX_WAIT=4): alu, mov and sys asserted in cycle 0, each dropped after its grant -> sys_gnt in cycle 0, alu_gnt in cycle 1, mov_gnt in cycle 2.
- Starvation (macro defined): sys_req held continuously with new data each cycle, and alu_req asserted from cycle 0 -> alu_gnt first asserts in cycle 4. With the macro undefined -> alu_gnt never asserts.
- Trap:
  - Sys write sets tf (flags=0x1000), then retire pulse -> trap_req=1 one edge later.
  - alu_req held meanwhile -> alu_gnt=0 throughout TRAP_WAIT.
  - trap_ack -> flags=0x0000 and trap_req=0 at that edge.
  - alu_gnt asserts in the next cycle.
- Same-cycle race: with tf=1, sys write with mask 0x1000 and data 0 issued in the same cycle as retire -> flags[12]=0 after the edge, and trap_req=1 is still raised.
